// File: rtl/ball_render_if.sv
// rtl/ball_render_if.sv - video timing in, registered colour/sync out for ball_render
interface ball_render_if;
    logic       h_sync;
    logic       v_sync;
    logic [8:0] line;
    logic [9:0] pixel;
    logic [7:0] rgb;
    logic       h_sync_o;
    logic       v_sync_o;

    modport master (
        output h_sync, v_sync, line, pixel,
        input  rgb, h_sync_o, v_sync_o
    );

    modport slave (
        input  h_sync, v_sync, line, pixel,
        output rgb, h_sync_o, v_sync_o
    );
endinterface

// File: rtl/ball_render.sv
// rtl/ball_render.sv - bouncing square sprite, moved once per frame during vertical blank
module ball_render #(
    parameter int       BALL_SIZE  = 16,
    parameter int       H_RES      = 640,
    parameter int       V_RES      = 480,
    parameter int       INIT_X     = 312,
    parameter int       INIT_Y     = 232,
    parameter bit [7:0] BALL_COLOR = 8'hFC,
    parameter bit [7:0] BG_COLOR   = 8'h03
) (
    input  logic        clk,
    input  logic        reset,
    ball_render_if.slave vid,
    input  logic [1:0]  speed,
    input  logic        pause,
    output logic [9:0]  ball_x,
    output logic [8:0]  ball_y,
    output logic [7:0]  bounce_cnt
);

    localparam logic [10:0] X_MAX  = 11'(H_RES - BALL_SIZE);
    localparam logic [10:0] Y_MAX  = 11'(V_RES - BALL_SIZE);
    localparam logic [10:0] B_SPAN = 11'(BALL_SIZE - 1);

    typedef enum logic [1:0] {
        WAIT_FRAME,
        STEP_X,
        STEP_Y
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_vs_prev;
    logic        r_tick_en;
    logic        r_dir_x;
    logic        r_dir_y;
    logic [2:0]  r_step;
    logic [9:0]  r_ball_x;
    logic [8:0]  r_ball_y;
    logic [7:0]  r_bounce;
    logic [7:0]  r_rgb;
    logic        r_hs_d;
    logic        r_vs_d;

    logic        w_tick;
    logic [10:0] w_step_ext;
    logic [10:0] w_x_ext;
    logic [10:0] w_y_ext;
    logic [10:0] w_x_fwd;
    logic [10:0] w_x_back;
    logic [10:0] w_y_fwd;
    logic [10:0] w_y_back;
    logic        w_x_hit_hi;
    logic        w_x_hit_lo;
    logic        w_y_hit_hi;
    logic        w_y_hit_lo;
    logic [7:0]  w_bounce_inc;
    logic        w_active;
    logic [10:0] w_px;
    logic [10:0] w_py;
    logic        w_hit;

    // r_tick_en masks the first cycle after reset so a low v_sync at release is not a frame edge
    assign w_tick = r_tick_en & r_vs_prev & ~vid.v_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= WAIT_FRAME;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            WAIT_FRAME: begin
                if (w_tick && !pause) begin
                    w_state_next = STEP_X;
                end
            end
            STEP_X:  w_state_next = STEP_Y;
            STEP_Y:  w_state_next = WAIT_FRAME;
            default: w_state_next = WAIT_FRAME;
        endcase
    end

    assign w_step_ext   = {8'b0, r_step};
    assign w_x_ext      = {1'b0, r_ball_x};
    assign w_y_ext      = {2'b0, r_ball_y};
    assign w_x_fwd      = w_x_ext + w_step_ext;
    assign w_x_back     = w_x_ext - w_step_ext;
    assign w_y_fwd      = w_y_ext + w_step_ext;
    assign w_y_back     = w_y_ext - w_step_ext;
    assign w_x_hit_hi   = (w_x_fwd > X_MAX);
    assign w_x_hit_lo   = (w_x_ext < w_step_ext);
    assign w_y_hit_hi   = (w_y_fwd > Y_MAX);
    assign w_y_hit_lo   = (w_y_ext < w_step_ext);
    assign w_bounce_inc = (r_bounce == 8'hFF) ? 8'hFF : r_bounce + 8'd1;

    // Each axis updates in its own cycle, so a corner hit counts twice without conflict
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_en <= 1'b0;
            r_dir_x   <= 1'b1;
            r_dir_y   <= 1'b1;
            r_step    <= 3'd1;
            r_ball_x  <= 10'(INIT_X);
            r_ball_y  <= 9'(INIT_Y);
            r_bounce  <= 8'd0;
        end else begin
            r_tick_en <= 1'b1;
            if (r_state == WAIT_FRAME && w_state_next == STEP_X) begin
                r_step <= {1'b0, speed} + 3'd1;
            end
            case (r_state)
                STEP_X: begin
                    if (r_dir_x) begin
                        if (w_x_hit_hi) begin
                            r_ball_x <= X_MAX[9:0];
                            r_dir_x  <= 1'b0;
                            r_bounce <= w_bounce_inc;
                        end else begin
                            r_ball_x <= w_x_fwd[9:0];
                        end
                    end else begin
                        if (w_x_hit_lo) begin
                            r_ball_x <= 10'd0;
                            r_dir_x  <= 1'b1;
                            r_bounce <= w_bounce_inc;
                        end else begin
                            r_ball_x <= w_x_back[9:0];
                        end
                    end
                end
                STEP_Y: begin
                    if (r_dir_y) begin
                        if (w_y_hit_hi) begin
                            r_ball_y <= Y_MAX[8:0];
                            r_dir_y  <= 1'b0;
                            r_bounce <= w_bounce_inc;
                        end else begin
                            r_ball_y <= w_y_fwd[8:0];
                        end
                    end else begin
                        if (w_y_hit_lo) begin
                            r_ball_y <= 9'd0;
                            r_dir_y  <= 1'b1;
                            r_bounce <= w_bounce_inc;
                        end else begin
                            r_ball_y <= w_y_back[8:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_active = (vid.line != 9'd0) && (vid.pixel != 10'd0);
    assign w_px     = {1'b0, vid.pixel} - 11'd1;
    assign w_py     = {2'b0, vid.line} - 11'd1;
    assign w_hit    = (w_px >= w_x_ext) && (w_px <= w_x_ext + B_SPAN) &&
                      (w_py >= w_y_ext) && (w_py <= w_y_ext + B_SPAN);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vs_prev <= 1'b1;
            r_hs_d    <= 1'b1;
            r_vs_d    <= 1'b1;
            r_rgb     <= 8'h00;
        end else begin
            r_vs_prev <= vid.v_sync;
            r_hs_d    <= vid.h_sync;
            r_vs_d    <= vid.v_sync;
            if (!w_active) begin
                r_rgb <= 8'h00;
            end else if (w_hit) begin
                r_rgb <= BALL_COLOR;
            end else begin
                r_rgb <= BG_COLOR;
            end
        end
    end

    assign vid.rgb      = r_rgb;
    assign vid.h_sync_o = r_hs_d;
    assign vid.v_sync_o = r_vs_d;
    assign ball_x       = r_ball_x;
    assign ball_y       = r_ball_y;
    assign bounce_cnt   = r_bounce;

endmodule

// File: tb/tb_ball_render.sv
// tb/tb_ball_render.sv - directed bench for ball_render over four parameterised instances
module tb_ball_render;

    logic       clk;
    logic       reset;
    logic [1:0] speed;
    logic       pause;
    int         checks;
    int         errors;

    ball_render_if ifa();
    ball_render_if ifb();
    ball_render_if ifc();
    ball_render_if ifd();

    logic [9:0] bx_a, bx_b, bx_c, bx_d;
    logic [8:0] by_a, by_b, by_c, by_d;
    logic [7:0] bc_a, bc_b, bc_c, bc_d;

    ball_render dut_a (
        .clk(clk), .reset(reset), .vid(ifa), .speed(speed), .pause(pause),
        .ball_x(bx_a), .ball_y(by_a), .bounce_cnt(bc_a)
    );

    ball_render #(.INIT_X(622)) dut_b (
        .clk(clk), .reset(reset), .vid(ifb), .speed(speed), .pause(pause),
        .ball_x(bx_b), .ball_y(by_b), .bounce_cnt(bc_b)
    );

    // Zero-travel arena: every step on both axes is a wall hit
    ball_render #(.H_RES(16), .V_RES(16), .INIT_X(0), .INIT_Y(0)) dut_c (
        .clk(clk), .reset(reset), .vid(ifc), .speed(speed), .pause(pause),
        .ball_x(bx_c), .ball_y(by_c), .bounce_cnt(bc_c)
    );

    ball_render #(.H_RES(32), .V_RES(32), .INIT_X(15), .INIT_Y(16)) dut_d (
        .clk(clk), .reset(reset), .vid(ifd), .speed(speed), .pause(pause),
        .ball_x(bx_d), .ball_y(by_d), .bounce_cnt(bc_d)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic frames(input logic [3:0] mask, input int n);
        for (int i = 0; i < n; i++) begin
            if (mask[0]) ifa.v_sync = 1'b0;
            if (mask[1]) ifb.v_sync = 1'b0;
            if (mask[2]) ifc.v_sync = 1'b0;
            if (mask[3]) ifd.v_sync = 1'b0;
            step(1);
            ifa.v_sync = 1'b1;
            ifb.v_sync = 1'b1;
            ifc.v_sync = 1'b1;
            ifd.v_sync = 1'b1;
            step(4);
        end
    endtask

    initial begin
        clk    = 1'b0;
        reset  = 1'b1;
        speed  = 2'd0;
        pause  = 1'b0;
        checks = 0;
        errors = 0;
        ifa.h_sync = 1'b1; ifa.v_sync = 1'b0; ifa.line = 9'd0; ifa.pixel = 10'd0;
        ifb.h_sync = 1'b1; ifb.v_sync = 1'b1; ifb.line = 9'd0; ifb.pixel = 10'd0;
        ifc.h_sync = 1'b1; ifc.v_sync = 1'b1; ifc.line = 9'd0; ifc.pixel = 10'd0;
        ifd.h_sync = 1'b1; ifd.v_sync = 1'b1; ifd.line = 9'd0; ifd.pixel = 10'd0;
        step(2);

        chk("rst_ball_x", bx_a, 312);
        chk("rst_ball_y", by_a, 232);
        chk("rst_bounce", bc_a, 0);
        chk("rst_rgb", ifa.rgb, 8'h00);
        chk("rst_hs_o", ifa.h_sync_o, 1);
        chk("rst_vs_o", ifa.v_sync_o, 1);

        // v_sync already low at release must not count as a frame edge
        reset = 1'b0;
        step(4);
        chk("no_tick_after_reset", bx_a, 312);
        ifa.v_sync = 1'b1;
        step(1);

        ifa.line = 9'd233; ifa.pixel = 10'd313; step(1);
        chk("rgb_hit_topleft", ifa.rgb, 8'hFC);
        ifa.pixel = 10'd328; step(1);
        chk("rgb_hit_right_edge", ifa.rgb, 8'hFC);
        ifa.pixel = 10'd329; step(1);
        chk("rgb_bg_right_of_ball", ifa.rgb, 8'h03);
        ifa.pixel = 10'd312; step(1);
        chk("rgb_bg_left_of_ball", ifa.rgb, 8'h03);
        ifa.line = 9'd248; ifa.pixel = 10'd313; step(1);
        chk("rgb_hit_bottom_row", ifa.rgb, 8'hFC);
        ifa.line = 9'd249; step(1);
        chk("rgb_bg_below_ball", ifa.rgb, 8'h03);
        ifa.line = 9'd0; step(1);
        chk("rgb_blank_line0", ifa.rgb, 8'h00);
        ifa.line = 9'd233; ifa.pixel = 10'd0; step(1);
        chk("rgb_blank_pixel0", ifa.rgb, 8'h00);
        ifa.line = 9'd0;

        ifa.h_sync = 1'b0; step(1);
        chk("hs_o_delayed_low", ifa.h_sync_o, 0);
        ifa.h_sync = 1'b1; step(1);
        chk("hs_o_delayed_high", ifa.h_sync_o, 1);

        ifa.v_sync = 1'b0; step(1);
        ifa.v_sync = 1'b1; step(1);
        chk("step1_x_after_stepx", bx_a, 313);
        chk("step1_y_before_stepy", by_a, 232);
        step(1);
        chk("step1_y_after_stepy", by_a, 233);
        chk("step1_bounce", bc_a, 0);
        step(2);

        pause = 1'b1;
        frames(4'b0001, 3);
        chk("pause_x", bx_a, 313);
        chk("pause_y", by_a, 233);
        chk("pause_bounce", bc_a, 0);
        ifa.v_sync = 1'b0; step(1);
        chk("vs_o_delayed_low", ifa.v_sync_o, 0);
        ifa.v_sync = 1'b1; step(1);
        chk("vs_o_delayed_high", ifa.v_sync_o, 1);
        chk("pause_x_after_vs", bx_a, 313);
        pause = 1'b0;
        step(2);

        // Step size is captured at the tick; a later speed change must not affect this frame
        speed = 2'd3;
        ifa.v_sync = 1'b0; step(1);
        speed = 2'd0;
        ifa.v_sync = 1'b1; step(4);
        chk("latched_speed_x", bx_a, 317);
        chk("latched_speed_y", by_a, 237);

        speed = 2'd3;
        frames(4'b0010, 1);
        chk("right_wall_x", bx_b, 624);
        chk("right_wall_bounce", bc_b, 1);
        frames(4'b0010, 1);
        chk("after_right_wall_x", bx_b, 620);
        chk("after_right_wall_y", by_b, 240);
        chk("after_right_wall_bounce", bc_b, 1);

        speed = 2'd0;
        frames(4'b0100, 1);
        chk("corner_bounce_twice", bc_c, 2);
        chk("corner_x", bx_c, 0);
        chk("corner_y", by_c, 0);
        frames(4'b0100, 126);
        chk("bounce_254", bc_c, 254);
        frames(4'b0100, 1);
        chk("bounce_sat_255", bc_c, 255);
        frames(4'b0100, 1);
        chk("bounce_stays_255", bc_c, 255);

        speed = 2'd0;
        frames(4'b1000, 1);
        chk("d_f1_x", bx_d, 16);
        chk("d_f1_y", by_d, 16);
        chk("d_f1_bounce", bc_d, 1);
        frames(4'b1000, 1);
        chk("d_f2_x", bx_d, 16);
        chk("d_f2_y", by_d, 15);
        chk("d_f2_bounce", bc_d, 2);
        speed = 2'd3;
        frames(4'b1000, 3);
        chk("d_f5_x", bx_d, 4);
        chk("d_f5_y", by_d, 3);
        speed = 2'd1;
        frames(4'b1000, 1);
        chk("d_near_corner_x", bx_d, 2);
        chk("d_near_corner_y", by_d, 1);
        chk("d_near_corner_bounce", bc_d, 2);
        frames(4'b1000, 1);
        chk("d_land_x0", bx_d, 0);
        chk("d_hit_y0", by_d, 0);
        chk("d_hit_y_bounce", bc_d, 3);
        frames(4'b1000, 1);
        chk("d_hit_x0_stays", bx_d, 0);
        chk("d_y_moving_down", by_d, 2);
        chk("d_hit_x_bounce", bc_d, 4);
        frames(4'b1000, 1);
        chk("d_x_moving_right", bx_d, 2);
        chk("d_y_still_down", by_d, 4);
        chk("d_no_bounce", bc_d, 4);

        // Reset landing on the STEP_Y edge must discard the in-flight update
        speed = 2'd0;
        ifa.line = 9'd240; ifa.pixel = 10'd320; ifa.h_sync = 1'b0;
        ifa.v_sync = 1'b0; ifc.v_sync = 1'b0; step(1);
        ifa.v_sync = 1'b1; ifc.v_sync = 1'b1; step(1);
        chk("mid_x_updated", bx_a, 318);
        chk("mid_rgb_ball", ifa.rgb, 8'hFC);
        chk("mid_hs_o_low", ifa.h_sync_o, 0);
        reset = 1'b1; step(1);
        chk("mid_rst_x", bx_a, 312);
        chk("mid_rst_y", by_a, 232);
        chk("mid_rst_bounce", bc_a, 0);
        chk("mid_rst_rgb", ifa.rgb, 8'h00);
        chk("mid_rst_hs_o", ifa.h_sync_o, 1);
        chk("mid_rst_vs_o", ifa.v_sync_o, 1);
        chk("mid_rst_sat_bounce", bc_c, 0);
        reset = 1'b0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
